// File: rtl/usbdev_line_if.sv
// Pin-side inputs and decoded line-state outputs of the USB device line monitor.
// The monitor takes the slave view and the pin/link-state logic takes the master view.
interface usbdev_line_if;
    logic       enable_i;
    logic       pinflip_i;
    logic       usb_dp_i;
    logic       usb_dn_i;
    logic       usb_oe_i;
    logic       us_tick_o;
    logic [1:0] line_state_o;
    logic       rx_idle_det_o;
    logic       rx_j_det_o;
    logic       se1_seen_o;

    modport master (
        output enable_i, pinflip_i, usb_dp_i, usb_dn_i, usb_oe_i,
        input  us_tick_o, line_state_o, rx_idle_det_o, rx_j_det_o, se1_seen_o
    );

    modport slave (
        input  enable_i, pinflip_i, usb_dp_i, usb_dn_i, usb_oe_i,
        output us_tick_o, line_state_o, rx_idle_det_o, rx_j_det_o, se1_seen_o
    );
endinterface

// File: rtl/usbdev_line_monitor.sv
// USB line-state front end: D+/D- decode, deglitch filter, idle/J detection, sticky SE1
// flag and a free-running 1 us tick for the link-state timers.
module usbdev_line_monitor #(
    parameter int unsigned ClkPerUs   = 48,
    parameter int unsigned ClkPerBit  = 4,
    parameter int unsigned FiltCycles = 3,
    parameter int unsigned IdleBits   = 8
) (
    input logic          clk_48mhz_i,
    input logic          rst_ni,
    usbdev_line_if.slave line_io
);
    localparam int unsigned TickW   = $clog2(ClkPerUs);
    localparam int unsigned StabW   = (FiltCycles > 1) ? $clog2(FiltCycles) : 1;
    localparam int unsigned IdleMax = IdleBits * ClkPerBit;
    localparam int unsigned IdleW   = $clog2(IdleMax + 1);
    localparam int unsigned NonjW   = $clog2(ClkPerBit + 1);

    localparam logic [TickW-1:0] TickLast = TickW'(ClkPerUs - 1);
    localparam logic [StabW-1:0] StabLast = StabW'(FiltCycles - 1);
    localparam logic [IdleW-1:0] IdleSat  = IdleW'(IdleMax);
    localparam logic [NonjW-1:0] NonjSat  = NonjW'(ClkPerBit);

    localparam logic [1:0] LsSe0 = 2'd0;
    localparam logic [1:0] LsJ   = 2'd1;
    localparam logic [1:0] LsK   = 2'd2;
    localparam logic [1:0] LsSe1 = 2'd3;

    logic [TickW-1:0] tick_cnt_q;
    logic [1:0]       raw_dec;
    logic             dp_eff, dn_eff;
    logic [1:0]       raw_q, raw_d;
    logic [StabW-1:0] stab_q, stab_d;
    logic [1:0]       line_q, line_d;
    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
    logic             idle_det_q, idle_det_d;
    logic [NonjW-1:0] nonj_q, nonj_d;
    logic             j_det_q, j_det_d;
    logic             se1_q, se1_d;
    logic             line_q_nonj;

    // Tick runs regardless of enable/oe so the downstream timers never stall.
    always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tick_cnt_q <= '0;
        end else if (tick_cnt_q == TickLast) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TickW'(1);
        end
    end

    always_comb begin
        dp_eff = line_io.pinflip_i ? line_io.usb_dn_i : line_io.usb_dp_i;
        dn_eff = line_io.pinflip_i ? line_io.usb_dp_i : line_io.usb_dn_i;
        raw_dec = LsSe1;
        case ({dp_eff, dn_eff})
            2'b00:   raw_dec = LsSe0;
            2'b10:   raw_dec = LsJ;
            2'b01:   raw_dec = LsK;
            default: raw_dec = LsSe1;
        endcase
    end

    assign line_q_nonj = (line_q == LsK) || (line_q == LsSe0);

    always_comb begin
        raw_d      = raw_q;
        stab_d     = stab_q;
        line_d     = line_q;
        idle_cnt_d = idle_cnt_q;
        idle_det_d = 1'b0;
        nonj_d     = nonj_q;
        j_det_d    = 1'b0;
        se1_d      = se1_q;
        if (!line_io.enable_i) begin
            raw_d      = LsJ;
            stab_d     = '0;
            line_d     = LsJ;
            idle_cnt_d = '0;
            nonj_d     = '0;
            se1_d      = 1'b0;
        end else if (line_io.usb_oe_i) begin
            // Our own drive is on the bus: freeze the filter, forget bus history.
            idle_cnt_d = '0;
            nonj_d     = '0;
        end else begin
            raw_d = raw_dec;
            if (raw_dec != raw_q) begin
                stab_d = '0;
            end else if (stab_q == StabLast) begin
                line_d = raw_q;
            end else begin
                stab_d = stab_q + StabW'(1);
            end

            if (line_q != LsJ) begin
                idle_cnt_d = '0;
            end else if (idle_cnt_q != IdleSat) begin
                idle_cnt_d = idle_cnt_q + IdleW'(1);
            end
            idle_det_d = (line_q == LsJ) && (idle_cnt_q == IdleSat);

            if (line_q_nonj && (line_d == LsJ)) begin
                j_det_d = (nonj_q == NonjSat);
                nonj_d  = '0;
            end else if (line_q_nonj) begin
                if (nonj_q != NonjSat) begin
                    nonj_d = nonj_q + NonjW'(1);
                end
            end else begin
                nonj_d = '0;
            end

            se1_d = se1_q | (line_d == LsSe1);
        end
    end

    always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
        if (!rst_ni) begin
            raw_q      <= LsJ;
            stab_q     <= '0;
            line_q     <= LsJ;
            idle_cnt_q <= '0;
            idle_det_q <= 1'b0;
            nonj_q     <= '0;
            j_det_q    <= 1'b0;
            se1_q      <= 1'b0;
        end else begin
            raw_q      <= raw_d;
            stab_q     <= stab_d;
            line_q     <= line_d;
            idle_cnt_q <= idle_cnt_d;
            idle_det_q <= idle_det_d;
            nonj_q     <= nonj_d;
            j_det_q    <= j_det_d;
            se1_q      <= se1_d;
        end
    end

    assign line_io.us_tick_o     = (tick_cnt_q == TickLast);
    assign line_io.line_state_o  = line_q;
    assign line_io.rx_idle_det_o = idle_det_q;
    assign line_io.rx_j_det_o    = j_det_q;
    assign line_io.se1_seen_o    = se1_q;
endmodule
